sr_pulse_driver: RTL
====================

# sr_pulse_driver

Command-side driver for the team's two-input set/clear `flipflop` cell. It accepts set/clear requests over a valid/ready handshake and emits a clean pulse on the cell's `in1` (set) or `in2` (clear) input. It then watches the cell's `out` feedback until it shows the requested value, or until a timeout expires. It reports completion and error per request and keeps a saturating error count. It sits between a control FSM or host register and one `flipflop` instance.

## Interface
- `PULSE_LEN`, default 1: cycles `in1`/`in2` is held high per request; must be ≥1.
- `GAP`, default 1: idle cycles after completion before the next request is accepted; must be ≥1.
- `TIMEOUT`, default 8: WAIT-state samples before an error is declared; must be ≥1.
- `CNT_W`, default 8: width of `err_cnt`.

- `clk`, in, 1: the single clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: a request is present.
- `req_cmd`, in, 1: 1 = set (`in1`), 0 = clear (`in2`).
- `req_ready`, out, 1: high only in IDLE.
- `in1`, out, 1: set pulse to the flipflop; registered.
- `in2`, out, 1: clear pulse to the flipflop; registered.
- `out_fb`, in, 1: the flipflop `out`.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle completion strobe.
- `err`, out, 1: qualifies `done`; 1 = timeout.
- `err_cnt`, out, `CNT_W`: saturating count of timeouts.

## Operation
- Reset (asynchronous, immediate): state IDLE; `in1`=`in2`=`done`=`err`=`busy`=0; `err_cnt`=0; `req_ready`=1. Requests are ignored while `rst` is high.
- State machine states: IDLE, PULSE, WAIT, GAP.
  - IDLE: `req_ready`=1. A handshake (`req_valid`&&`req_ready` at an edge) latches `target`=`req_cmd` and moves to PULSE.
  - PULSE: drives `in1`=`target` and `in2`=!`target` for `PULSE_LEN` cycles, then moves to WAIT.
  - WAIT: `in1`=`in2`=0. `out_fb` is sampled every edge.
    - `out_fb`==`target`: go to GAP with `done`=1, `err`=0.
    - Sample count reaches `TIMEOUT` without a match: go to GAP with `done`=1, `err`=1, and `err_cnt` incremented.
  - GAP: holds for `GAP` cycles, then returns to IDLE.
- `in1` and `in2` are never high simultaneously.
- `err_cnt` saturates at 2^`CNT_W`−1 and does not wrap.
- A request whose target already equals `out_fb` still pulses, and completes on the first WAIT sample.
- Reset asserted mid-PULSE drops `in1`/`in2` to 0 immediately and abandons the request; no `done` is issued.
- The pulse and timeout counters are sized to hold max(`PULSE_LEN`, `GAP`, `TIMEOUT`).

## Timing
- Edge numbering: the handshake occurs at edge E.
- `in1`/`in2` high from E to E+`PULSE_LEN`.
- WAIT samples `out_fb` at edges E+`PULSE_LEN`+k, for k=1..`TIMEOUT`.
- On a match at sample k, `done` is high from E+`PULSE_LEN`+k to E+`PULSE_LEN`+k+1.
- On timeout, `done`=`err`=1 from E+`PULSE_LEN`+`TIMEOUT` for one cycle.
- `req_ready` returns high `GAP` cycles after `done` asserts.
- With a standard registered flipflop and defaults, request-to-`done` latency is 2 cycles. Minimum back-to-back request spacing is 3 cycles.

## Configuration
- `SR_DRV_TIMEOUT_EN` defined: timeout counter present; behaviour as above.
- `SR_DRV_TIMEOUT_EN` undefined:
  - No timeout counter; WAIT holds indefinitely until a match.
  - `err` is tied to 0 and `err_cnt` is tied to 0.
  - `TIMEOUT` is ignored.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs reach their reset values immediately; `req_ready`=1 after release.
- Set with defaults: request `req_cmd`=1 at edge E; `out_fb` rises after E+1 → `in1`=1 for E..E+1, `done`=1 and `err`=0 at E+2, `req_ready`=1 at E+3.
- Clear after set: `req_cmd`=0 → only `in2` pulses; `done`=1 two cycles after accept; `in1` stays 0 throughout.
- Timeout: hold `out_fb`=0 on a set request, `TIMEOUT`=8 → `done`=`err`=1 at E+9 and `err_cnt` increments 0→1; with `SR_DRV_TIMEOUT_EN` undefined, `busy` stays 1 for 100 cycles.
- Saturation: with `CNT_W`=2, run 5 timed-out requests → `err_cnt` sequence 1,2,3,3,3.
- Reset mid-operation: assert `rst` during PULSE with `PULSE_LEN`=4 → `in1` drops at once, no `done`, and the next request completes normally.

Source files
------------

// File: rtl/sr_pulse_driver_if.sv
// ----------------------------------------------------------------------------
// sr_pulse_driver_if
//
// Purpose:
//    Request handshake between a command source (control FSM or host register)
//    and the sr_pulse_driver. A request is accepted on any rising clock edge
//    where req_valid and req_ready are both high.
//
// Signals:
//    req_valid  master -> slave  a request is present
//    req_cmd    master -> slave  1 = set the flipflop, 0 = clear it
//    req_ready  slave -> master  driver is idle and can accept a request
//
// Modports:
//    master  command source side
//    slave   sr_pulse_driver side
// ----------------------------------------------------------------------------
interface sr_pulse_driver_if;

   logic req_valid;
   logic req_cmd;
   logic req_ready;

   modport master (
      output req_valid,
      output req_cmd,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_cmd,
      output req_ready
   );

endinterface

// File: rtl/sr_pulse_driver.sv
// ----------------------------------------------------------------------------
// sr_pulse_driver
//
// Purpose:
//    Command-side driver for the two-input set/clear flipflop cell. Each
//    accepted request produces a clean registered pulse on in1 (set) or in2
//    (clear). The driver then watches the cell output until it shows the
//    requested value, strobes done, and waits a short gap before accepting
//    the next request.
//
// Optional feature (macro SR_DRV_TIMEOUT_EN):
//    defined   : a timeout counter limits the WAIT state to TIMEOUT samples.
//                On expiry, done and err strobe together and err_cnt
//                increments, saturating at all-ones.
//    undefined : WAIT holds until the cell output matches. err and err_cnt
//                are tied to zero and TIMEOUT has no effect.
//
// Parameters:
//    PULSE_LEN  cycles in1/in2 is held high per request (>= 1)
//    GAP        idle cycles after done before the next request (>= 1)
//    TIMEOUT    WAIT samples before a timeout is declared (>= 1)
//    CNT_W      width of err_cnt
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    req        request handshake (slave modport of sr_pulse_driver_if)
//    in1        registered set pulse to the flipflop
//    in2        registered clear pulse to the flipflop
//    out_fb     flipflop output feedback
//    busy       high in every state except IDLE
//    done       one-cycle completion strobe
//    err        qualifies done, 1 = the request timed out
//    err_cnt    saturating count of timed-out requests
// ----------------------------------------------------------------------------
module sr_pulse_driver #(
   parameter int PULSE_LEN = 1,
   parameter int GAP       = 1,
   parameter int TIMEOUT   = 8,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   sr_pulse_driver_if.slave     req,
   output logic                 in1,
   output logic                 in2,
   input  logic                 out_fb,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CNT_W-1:0]     err_cnt
);

   // One shared counter serves the pulse, wait and gap phases, so it must
   // hold the largest of the three lengths.
   localparam int MAX_PG  = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
   localparam int MAX_LEN = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
   localparam int CW      = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN + 1);

   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_WAIT,
      ST_GAP
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           target;
   logic           ready_q;

`ifdef SR_DRV_TIMEOUT_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

   logic             err_q;
   logic [CNT_W-1:0] err_cnt_q;

   assign err     = err_q;
   assign err_cnt = err_cnt_q;
`else
   assign err     = 1'b0;
   assign err_cnt = '0;
`endif

   assign req.req_ready = ready_q;

   // Main controller. All outputs are registered alongside the state so
   // the flipflop cell and the command source never see decode glitches.
   // in1 and in2 are only ever loaded with complementary values (PULSE
   // entry) or both cleared, so they cannot be high together. Reset clears
   // the pulse outputs at once and abandons any request in flight without
   // a done strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         target    <= 1'b0;
         ready_q   <= 1'b1;
         in1       <= 1'b0;
         in2       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SR_DRV_TIMEOUT_EN
         err_q     <= 1'b0;
         err_cnt_q <= '0;
`endif
      end else begin
         done  <= 1'b0;
`ifdef SR_DRV_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (req.req_valid) begin
                  target  <= req.req_cmd;
                  in1     <= req.req_cmd;
                  in2     <= !req.req_cmd;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  ready_q <= 1'b0;
                  state   <= ST_PULSE;
               end
            end

            ST_PULSE: begin
               if (cnt == PULSE_LAST) begin
                  in1   <= 1'b0;
                  in2   <= 1'b0;
                  cnt   <= '0;
                  state <= ST_WAIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_WAIT: begin
               // A match wins over an expiring timeout on the same sample.
               if (out_fb == target) begin
                  done  <= 1'b1;
                  cnt   <= '0;
                  state <= ST_GAP;
`ifdef SR_DRV_TIMEOUT_EN
               end else if (cnt == TIMEOUT_LAST) begin
                  done  <= 1'b1;
                  err_q <= 1'b1;
                  if (err_cnt_q != {CNT_W{1'b1}}) begin
                     err_cnt_q <= err_cnt_q + 1'b1;
                  end
                  cnt   <= '0;
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end

            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  busy    <= 1'b0;
                  ready_q <= 1'b1;
                  cnt     <= '0;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               in1     <= 1'b0;
               in2     <= 1'b0;
               busy    <= 1'b0;
               ready_q <= 1'b1;
               cnt     <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
